// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   ctrl_state_e       : FSM state encoding (RUN, MEM_WAIT, FAULT), 2 bits
//   MemTimeoutDefault  : default max cycles spent in MEM_WAIT before a fault
//   StallCntWDefault   : default width of the stall performance counter
//   load_use()         : load-use hazard detect between ID/EX load and IF/ID sources
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      StRun     = 2'd0,
      StMemWait = 2'd1,
      StFault   = 2'd2
   } ctrl_state_e;

   localparam int unsigned MemTimeoutDefault = 15;
   localparam int unsigned StallCntWDefault  = 16;

   // r0 is hardwired zero, so a load "to r0" never creates a dependency.
   function automatic logic load_use(input logic       ex_memread,
                                     input logic [4:0] ex_rt,
                                     input logic [4:0] id_rs,
                                     input logic [4:0] id_rt,
                                     input logic       id_uses_rt);
      return ex_memread && (ex_rt != 5'd0) &&
             ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall-cycle performance count.
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-low reset, clears the count
//   en_i  : increment this cycle
//   cnt_o : current count, sticks at all-ones instead of wrapping
module sat_counter #(
   parameter int unsigned Width = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   output logic [Width-1:0] cnt_o
);

   logic [Width-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en_i && (cnt_q != {Width{1'b1}})) begin
         cnt_d = cnt_q + Width'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, data-memory
// wait stall with timeout fault, and a saturating stall-cycle counter.
//   clk_i, rst_i            : clock and asynchronous active-low reset
//   id_rs_i, id_rt_i        : IF/ID source registers; id_uses_rt_i qualifies rt
//   ex_memread_i, ex_rt_i   : ID/EX load flag and its destination register
//   branch_taken_i          : branch resolved taken in ID this cycle
//   mem_req_i, mem_ready_i  : EX/MEM memory access and its completion
//   *_write_o               : load enables of PC and pipeline registers
//   if_id_flush_o           : zero IF/ID on next edge
//   id_ex_bubble_o          : zero ID/EX control bits
//   mem_wb_bubble_o         : zero MEM/WB RegWrite/Mem2Reg
//   fault_o                 : sticky memory-timeout fault (cleared only by reset)
//   stall_cnt_o             : count of cycles with pc_write_o low, saturating
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = MemTimeoutDefault,
   parameter int unsigned CNT_W       = StallCntWDefault
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [4:0]       id_rs_i,
   input  logic [4:0]       id_rt_i,
   input  logic             id_uses_rt_i,
   input  logic             ex_memread_i,
   input  logic [4:0]       ex_rt_i,
   input  logic             branch_taken_i,
   input  logic             mem_req_i,
   input  logic             mem_ready_i,
   output logic             pc_write_o,
   output logic             if_id_write_o,
   output logic             id_ex_write_o,
   output logic             ex_mem_write_o,
   output logic             if_id_flush_o,
   output logic             id_ex_bubble_o,
   output logic             mem_wb_bubble_o,
   output logic             fault_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WaitW-1:0] TimeoutVal = WaitW'(MEM_TIMEOUT);

   ctrl_state_e      state_q;
   logic [WaitW-1:0] wait_q;
   logic             mst;
   logic             lu;

   assign mst = ((state_q == StRun) && mem_req_i && !mem_ready_i) ||
                ((state_q == StMemWait) && !mem_ready_i);
   assign lu  = load_use(ex_memread_i, ex_rt_i, id_rs_i, id_rt_i, id_uses_rt_i);

   // wait_q counts MEM_WAIT cycles; entry loads 1 so the Nth MEM_WAIT cycle
   // sees wait_q == N and the fault fires at the end of cycle MEM_TIMEOUT.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= StRun;
         wait_q  <= '0;
      end else begin
         case (state_q)
            StRun: begin
               if (mem_req_i && !mem_ready_i) begin
                  state_q <= StMemWait;
                  wait_q  <= WaitW'(1);
               end
            end
            StMemWait: begin
               if (mem_ready_i) begin
                  state_q <= StRun;
                  wait_q  <= '0;
               end else if (wait_q == TimeoutVal) begin
                  state_q <= StFault;
               end else begin
                  wait_q <= wait_q + WaitW'(1);
               end
            end
            StFault: begin
               state_q <= StFault;
            end
            default: begin
               state_q <= StRun;
               wait_q  <= '0;
            end
         endcase
      end
   end

   // Priority: FAULT > memory stall > load-use > branch flush.
   always_comb begin
      pc_write_o      = 1'b1;
      if_id_write_o   = 1'b1;
      id_ex_write_o   = 1'b1;
      ex_mem_write_o  = 1'b1;
      if_id_flush_o   = 1'b0;
      id_ex_bubble_o  = 1'b0;
      mem_wb_bubble_o = 1'b0;
      if ((state_q == StFault) || mst) begin
         pc_write_o      = 1'b0;
         if_id_write_o   = 1'b0;
         id_ex_write_o   = 1'b0;
         ex_mem_write_o  = 1'b0;
         mem_wb_bubble_o = 1'b1;
      end else if (state_q == StRun) begin
         if (lu) begin
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_bubble_o = 1'b1;
         end else if (branch_taken_i) begin
            if_id_flush_o = 1'b1;
         end
      end
   end

   assign fault_o = (state_q == StFault);

   sat_counter #(
      .Width (CNT_W)
   ) u_stall_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (!pc_write_o),
      .cnt_o (stall_cnt_o)
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

   localparam int unsigned CntW = 5;

   // ctl order: {pc, if_id, id_ex, ex_mem, flush, id_ex_bubble, mem_wb_bubble}
   localparam logic [6:0] ERun = 7'b1111_000;
   localparam logic [6:0] ELu  = 7'b0011_010;
   localparam logic [6:0] EBr  = 7'b1111_100;
   localparam logic [6:0] EMst = 7'b0000_001;

   typedef struct {
      int              id;
      logic [6:0]      ctl;
      logic            fault;
      logic [CntW-1:0] cnt;
   } exp_t;

   logic            clk;
   logic            rst_i;
   logic [4:0]      id_rs, id_rt, ex_rt;
   logic            id_uses_rt, ex_memread, branch_taken, mem_req, mem_ready;
   logic            pc_write, if_id_write, id_ex_write, ex_mem_write;
   logic            if_id_flush, id_ex_bubble, mem_wb_bubble, fault;
   logic [CntW-1:0] stall_cnt;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   int   step_id = 0;

   pipe_hazard_ctrl #(
      .MEM_TIMEOUT (15),
      .CNT_W       (CntW)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst_i),
      .id_rs_i         (id_rs),
      .id_rt_i         (id_rt),
      .id_uses_rt_i    (id_uses_rt),
      .ex_memread_i    (ex_memread),
      .ex_rt_i         (ex_rt),
      .branch_taken_i  (branch_taken),
      .mem_req_i       (mem_req),
      .mem_ready_i     (mem_ready),
      .pc_write_o      (pc_write),
      .if_id_write_o   (if_id_write),
      .id_ex_write_o   (id_ex_write),
      .ex_mem_write_o  (ex_mem_write),
      .if_id_flush_o   (if_id_flush),
      .id_ex_bubble_o  (id_ex_bubble),
      .mem_wb_bubble_o (mem_wb_bubble),
      .fault_o         (fault),
      .stall_cnt_o     (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one cycle of inputs shortly after the rising edge and queues the
   // response expected at the following falling edge.
   task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                       input logic memread, input logic [4:0] ert, input logic br,
                       input logic req, input logic rdy, input logic rst,
                       input logic [6:0] ctl, input logic f, input logic [CntW-1:0] c);
      exp_t e;
      @(posedge clk);
      #2;
      id_rs        = rs;
      id_rt        = rt;
      id_uses_rt   = uses_rt;
      ex_memread   = memread;
      ex_rt        = ert;
      branch_taken = br;
      mem_req      = req;
      mem_ready    = rdy;
      rst_i        = rst;
      step_id++;
      e.id    = step_id;
      e.ctl   = ctl;
      e.fault = f;
      e.cnt   = c;
      sb_q.push_back(e);
   endtask

   task automatic idle(input logic rst, input logic f, input logic [CntW-1:0] c);
      step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, rst, ERun, f, c);
   endtask

   // Monitor: compares every falling edge for which a response is queued.
   always @(negedge clk) begin
      if (sb_q.size() > 0) begin
         exp_t e;
         logic [6:0] act;
         e = sb_q.pop_front();
         act = {pc_write, if_id_write, id_ex_write, ex_mem_write,
                if_id_flush, id_ex_bubble, mem_wb_bubble};
         checks++;
         if (act !== e.ctl || fault !== e.fault || stall_cnt !== e.cnt) begin
            errors++;
            $display("FAIL step%0d: got ctl=%b fault=%b cnt=%0d, need ctl=%b fault=%b cnt=%0d",
                     e.id, act, fault, stall_cnt, e.ctl, e.fault, e.cnt);
         end
      end
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_i = 1'b0; id_rs = '0; id_rt = '0; ex_rt = '0;
      id_uses_rt = 1'b0; ex_memread = 1'b0; branch_taken = 1'b0;
      mem_req = 1'b0; mem_ready = 1'b0;

      idle(1'b0, 1'b0, 5'd0);                              // reset state
      idle(1'b1, 1'b0, 5'd0);
      // load-use on rs
      step(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1, ELu, 1'b0, 5'd0);
      idle(1'b1, 1'b0, 5'd1);
      // load into r0 is never a hazard
      step(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, ERun, 1'b0, 5'd1);
      // load-use on rt, then same but rt not read
      step(5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, ELu, 1'b0, 5'd1);
      step(5'd3, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, ERun, 1'b0, 5'd2);
      // branch suppressed by load-use, then flush once lu clears
      step(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, ELu, 1'b0, 5'd2);
      step(5'd8, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, EBr, 1'b0, 5'd3);
      // memory wait: 3 frozen cycles (lu+branch masked in MEM_WAIT), then ready
      step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, EMst, 1'b0, 5'd3);
      step(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, EMst, 1'b0, 5'd4);
      step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, EMst, 1'b0, 5'd5);
      step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, ERun, 1'b0, 5'd6);
      idle(1'b1, 1'b0, 5'd6);
      // request completing immediately never stalls
      step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, ERun, 1'b0, 5'd6);
      // timeout: RUN stall cycle, 15 MEM_WAIT cycles, then FAULT
      step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, EMst, 1'b0, 5'd6);
      for (int k = 1; k <= 15; k++) begin
         step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, EMst, 1'b0,
              CntW'(6 + k));
      end
      // FAULT is sticky (ready, lu, branch all ignored); counter saturates at 31
      for (int i = 0; i < 12; i++) begin
         step(5'd8, 5'd0, 1'b0, i[0], 5'd8, i[1], 1'b1, i[2], 1'b1, EMst, 1'b1,
              (22 + i > 31) ? 5'd31 : CntW'(22 + i));
      end
      idle(1'b0, 1'b0, 5'd0);                              // reset clears FAULT
      idle(1'b1, 1'b0, 5'd0);
      // asynchronous reset while in MEM_WAIT, checked before any clock edge
      step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, EMst, 1'b0, 5'd0);
      step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, EMst, 1'b0, 5'd1);
      idle(1'b0, 1'b0, 5'd0);
      idle(1'b1, 1'b0, 5'd0);
      // after the async reset a taken branch flushes normally
      step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, EBr, 1'b0, 5'd0);

      for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
      #1;
      if (sb_q.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d responses left unchecked, need 0", sb_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, max cycles spent in MEM_WAIT before fault.
REQ-002 Parameter CNT_W, default 16, width of stall performance counter.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  asynchronous, active-low reset.
REQ-005 id_rs_i, id_rt_i  input  5 each  source register addresses of instruction in IF/ID.
REQ-006 id_uses_rt_i  input  1  IF/ID instruction reads rt.
REQ-007 ex_memread_i  input  1  ID/EX instruction is a load; ex_rt_i input 5 its destination.
REQ-008 branch_taken_i  input  1  branch resolved taken in ID this cycle.
REQ-009 mem_req_i  input  1  EX/MEM instruction accesses data memory; mem_ready_i input 1 memory completes this cycle.
REQ-010 pc_write_o, if_id_write_o, id_ex_write_o, ex_mem_write_o  output  1 each  load enables of PC and pipeline registers.
REQ-011 if_id_flush_o  output  1  zero IF/ID on next edge.
REQ-012 id_ex_bubble_o  output  1  force ID/EX control bits to zero.
REQ-013 mem_wb_bubble_o  output  1  force MEM/WB RegWrite and Mem2Reg to zero.
REQ-014 fault_o  output  1  sticky memory-timeout fault; stall_cnt_o output CNT_W stall-cycle count.

Function
REQ-015 FSM states RUN, MEM_WAIT, FAULT; encoding 2 bits, state register only sequential control element besides counters.
REQ-016 Stall/flush outputs combinational from current state and inputs; state, wait counter, stall counter registered.
REQ-017 Mem stall (mst) = (state==RUN & mem_req_i & ~mem_ready_i) | (state==MEM_WAIT & ~mem_ready_i).
REQ-018 mst: pc_write_o, if_id_write_o, id_ex_write_o, ex_mem_write_o = 0; mem_wb_bubble_o = 1; flush and id_ex_bubble = 0.
REQ-019 RUN & mem_req_i & ~mem_ready_i -> MEM_WAIT, wait counter loaded with 1.
REQ-020 MEM_WAIT & mem_ready_i -> RUN same cycle all enables = 1 (access completes, pipeline advances).
REQ-021 MEM_WAIT & ~mem_ready_i: wait counter +1; when counter == MEM_TIMEOUT and still ~mem_ready_i -> FAULT.
REQ-022 FAULT: all write enables 0, mem_wb_bubble_o=1, fault_o=1, no exit except reset.
REQ-023 Load-use (lu) = ex_memread_i & ex_rt_i!=0 & (ex_rt_i==id_rs_i | (id_uses_rt_i & ex_rt_i==id_rt_i)).
REQ-024 lu & ~mst in RUN: pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1, id_ex/ex_mem write=1, flush=0.
REQ-025 branch_taken_i & ~lu & ~mst in RUN: if_id_flush_o=1, pc_write_o=1.
REQ-026 Priority: FAULT > mst > lu > branch flush; lower events suppressed, not remembered.
REQ-027 No hazard: all write enables 1, all flush/bubble 0.
REQ-028 stall_cnt_o +1 each cycle pc_write_o==0 (incl. FAULT); saturates at all-ones, no wrap.
REQ-029 MEM_TIMEOUT==1: first non-ready cycle in MEM_WAIT faults.

Reset
REQ-030 rst_i low: state=RUN, wait counter=0, stall_cnt_o=0, fault_o=0, asynchronously, mid-wait or in FAULT.
REQ-031 During reset combinational outputs follow RUN rules from inputs.

Structure
REQ-032 State encoding and default MEM_TIMEOUT constant in shared package pipe_ctrl_pkg.
REQ-033 Single module; optional sub-module sat_counter for stall_cnt_o.

Verification
REQ-034 ex_memread_i=1, ex_rt_i=8, id_rs_i=8 -> pc_write_o=0, if_id_write_o=0, id_ex_bubble_o=1, stall_cnt_o +1.
REQ-035 ex_rt_i=0, id_rs_i=0, ex_memread_i=1 -> no stall, all enables 1.
REQ-036 mem_req_i=1, mem_ready_i low 3 cycles then high -> 3 frozen cycles, MEM_WAIT, RUN after ready, stall_cnt_o=3.
REQ-037 mem_ready_i never high, MEM_TIMEOUT=15 -> FAULT entered after 15th MEM_WAIT cycle, fault_o=1 until rst_i low.
REQ-038 branch_taken_i=1 with lu -> flush 0 that cycle; next cycle lu clear -> if_id_flush_o=1.
REQ-039 rst_i asserted in MEM_WAIT -> state RUN, counters 0 immediately, without clock edge.
